// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : mem_pkg
// Shared funct3 codes, FSM state type and access-size helper for the
// MEM-stage load/store sequencer.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : mem_access_ctrl_if
// EX request / WB response handshake bundle of the MEM-stage sequencer.
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : load_extend
// Sign/zero-extends assembled load data according to the load funct3.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_BU:   o_data = {24'd0, i_data[7:0]};
      F3_HU:   o_data = {16'd0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mem_access_ctrl
// MEM-stage load/store sequencer: range/format checks, misaligned byte split,
// load extension and EX/WB handshakes in front of the data RAM.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT  = 32'd40,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  mem_access_ctrl_if.slave   bus,
  output logic               ram_we,
  output logic               ram_half_en,
  output logic               ram_byte_en,
  output logic [2:0]         ram_funct3,
  output logic [31:0]        ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  state_t      r_state, w_state_nxt;
  logic        r_we, r_split, r_fault, r_drop;
  logic [2:0]  r_f3;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_asm, r_rdata;

  logic        w_accept, w_f3_ok, w_oor, w_mis, w_fault, w_last_byte;
  logic [2:0]  w_size, w_rsize;
  logic [1:0]  w_cnt_last;
  logic [32:0] w_end;
  logic [31:0] w_asm_nxt, w_ext_src, w_ext;

  assign w_accept = bus.req_valid && (r_state == IDLE) && !flush;
  assign w_size   = size_of(bus.req_funct3);

  always_comb begin
    w_f3_ok = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = !bus.req_we;
      default:          w_f3_ok = 1'b0;
    endcase
  end

  // 33-bit end address so wrap past 2^32 lands out of range
  assign w_end   = {1'b0, bus.req_addr} + {30'd0, w_size} - 33'd1;
  assign w_oor   = w_end >= {1'b0, ADDR_LIMIT};
  assign w_mis   = ((w_size == 3'd2) && bus.req_addr[0]) ||
                   ((w_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
  assign w_fault = !w_f3_ok || w_oor || (w_mis && !MISALIGN_EN);

  assign w_rsize     = size_of(r_f3);
  assign w_cnt_last  = w_rsize[1:0] - 2'd1;
  assign w_last_byte = !r_split || (r_cnt == w_cnt_last);

  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[{r_cnt, 3'b000} +: 8] = ram_rdata[7:0];
  end

  assign w_ext_src = r_split ? w_asm_nxt : ram_rdata;

  load_extend u_ext (
    .i_data   (w_ext_src),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_state_nxt = w_fault ? RESP : ACCESS;
      // stores always complete every byte; only loads abort mid-access
      ACCESS: if (!r_we && flush)  w_state_nxt = IDLE;
              else if (w_last_byte) w_state_nxt = (r_we && (r_drop || flush)) ? IDLE : RESP;
      RESP:   if (flush || bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_f3    <= F3_W;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_split <= 1'b0;
      r_cnt   <= 2'd0;
      r_asm   <= 32'd0;
      r_drop  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_f3    <= bus.req_funct3;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_split <= w_mis && !w_fault;
      r_cnt   <= 2'd0;
      r_asm   <= 32'd0;
      r_drop  <= 1'b0;
      r_fault <= w_fault;
      r_rdata <= 32'd0;
    end else if (r_state == ACCESS) begin
      if (flush) r_drop <= 1'b1;
      if (r_split) begin
        r_asm <= w_asm_nxt;
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_last_byte && !r_we) r_rdata <= w_ext;
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_half_en = 1'b0;
    ram_byte_en = 1'b0;
    ram_funct3  = r_split ? F3_BU : r_f3;
    ram_addr    = r_addr + {30'd0, r_cnt};
    ram_wdata   = r_split ? {24'd0, r_wdata[{r_cnt, 3'b000} +: 8]} : r_wdata;
    if (r_state == ACCESS && r_we) begin
      ram_we      = 1'b1;
      ram_half_en = !r_split && (r_f3 == F3_H);
      ram_byte_en = r_split || (r_f3 == F3_B);
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl with a byte-array RAM model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus0 ();

  logic        ram_we, ram_half_en, ram_byte_en;
  logic [2:0]  ram_funct3;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        r0_we, r0_half_en, r0_byte_en;
  logic [2:0]  r0_funct3;
  logic [31:0] r0_addr, r0_wdata;

  mem_access_ctrl #(.ADDR_LIMIT(32'd40), .MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .ram_we(ram_we), .ram_half_en(ram_half_en), .ram_byte_en(ram_byte_en),
    .ram_funct3(ram_funct3), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_access_ctrl #(.ADDR_LIMIT(32'd40), .MISALIGN_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus0),
    .ram_we(r0_we), .ram_half_en(r0_half_en), .ram_byte_en(r0_byte_en),
    .ram_funct3(r0_funct3), .ram_addr(r0_addr), .ram_wdata(r0_wdata),
    .ram_rdata(32'd0)
  );

  // RAM model: raw little-endian read, byte/half/word write
  logic [7:0]  mem [0:39];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];
  int          we_cnt = 0;

  function automatic logic [7:0] rd8(input logic [31:0] a);
    rd8 = (a < 32'd40) ? mem[a] : 8'h00;
  endfunction

  always_comb ram_rdata = {rd8(ram_addr + 32'd3), rd8(ram_addr + 32'd2),
                           rd8(ram_addr + 32'd1), rd8(ram_addr)};

  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      if (ram_byte_en) begin
        if (ram_addr < 32'd40) mem[ram_addr] <= ram_wdata[7:0];
        wr_a.push_back(ram_addr);
        wr_d.push_back(ram_wdata[7:0]);
      end else if (ram_half_en) begin
        for (int b = 0; b < 2; b++)
          if (ram_addr + b < 32'd40) mem[ram_addr + b] <= ram_wdata[8*b +: 8];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_addr + b < 32'd40) mem[ram_addr + b] <= ram_wdata[8*b +: 8];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic flt, output int lat);
    int k;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(posedge clk); #1; k++; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; k = 0;
    while (!bus.resp_valid && k < 20) begin @(posedge clk); #1; lat++; k++; end
    if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rd  = bus.resp_rdata;
    flt = bus.resp_fault;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat;
  logic        seen;
  logic [7:0]  exp_b [4];

  initial begin
    for (int i = 0; i < 40; i++) mem[i] = 8'h00;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.resp_ready = 1;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_funct3 = 0; bus0.req_addr = 0;
    bus0.req_wdata = 0; bus0.resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("rst_ram_en", {29'd0, ram_we, ram_half_en, ram_byte_en}, 32'd0);
    chk("rst_ram_funct3", {29'd0, ram_funct3}, 32'd2);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // aligned word store/load
    do_req(1'b1, F3_W, 32'd8, 32'h11223344, rd, flt, lat);
    chk("sw8_fault", {31'd0, flt}, 32'd0);
    chk("sw8_lat", lat, 32'd2);
    do_req(1'b0, F3_W, 32'd8, 32'd0, rd, flt, lat);
    chk("lw8_data", rd, 32'h11223344);
    chk("lw8_fault", {31'd0, flt}, 32'd0);
    chk("lw8_lat", lat, 32'd2);

    // byte store and sign/zero extension
    do_req(1'b1, F3_B, 32'd5, 32'h00000080, rd, flt, lat);
    do_req(1'b0, F3_B, 32'd5, 32'd0, rd, flt, lat);
    chk("lb5_data", rd, 32'hFFFFFF80);
    do_req(1'b0, F3_BU, 32'd5, 32'd0, rd, flt, lat);
    chk("lbu5_data", rd, 32'h00000080);

    // misaligned word store split into four byte writes
    wr_a.delete(); wr_d.delete();
    exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    do_req(1'b1, F3_W, 32'd13, 32'hAABBCCDD, rd, flt, lat);
    chk("sw13_lat", lat, 32'd5);
    chk("sw13_nwr", wr_a.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      chk("sw13_addr", wr_a[i], 32'd13 + i);
      chk("sw13_byte", {24'd0, wr_d[i]}, {24'd0, exp_b[i]});
    end
    do_req(1'b0, F3_W, 32'd13, 32'd0, rd, flt, lat);
    chk("lw13_data", rd, 32'hAABBCCDD);
    chk("lw13_lat", lat, 32'd5);
    do_req(1'b0, F3_HU, 32'd15, 32'd0, rd, flt, lat);
    chk("lhu15_data", rd, 32'h0000AABB);
    chk("lhu15_lat", lat, 32'd3);

    // range boundary and illegal requests
    we_cnt = 0;
    do_req(1'b0, F3_W, 32'd38, 32'd0, rd, flt, lat);
    chk("lw38_fault", {31'd0, flt}, 32'd1);
    chk("lw38_data", rd, 32'd0);
    do_req(1'b1, F3_W, 32'd38, 32'h12345678, rd, flt, lat);
    chk("sw38_fault", {31'd0, flt}, 32'd1);
    do_req(1'b1, F3_BU, 32'd4, 32'h12345678, rd, flt, lat);
    chk("sbu_fault", {31'd0, flt}, 32'd1);
    do_req(1'b0, F3_W, 32'hFFFFFFFE, 32'd0, rd, flt, lat);
    chk("lw_wrap_fault", {31'd0, flt}, 32'd1);
    chk("fault_no_we", we_cnt, 32'd0);
    do_req(1'b0, F3_W, 32'd36, 32'd0, rd, flt, lat);
    chk("lw36_fault", {31'd0, flt}, 32'd0);
    chk("lw36_data", rd, 32'd0);

    // misalignment fault when splitting is disabled
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_funct3 = F3_H; bus0.req_addr = 32'd3;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    chk("nomis_lh3_valid", {31'd0, bus0.resp_valid}, 32'd1);
    chk("nomis_lh3_fault", {31'd0, bus0.resp_fault}, 32'd1);
    @(posedge clk); #1;

    // WB back-pressure
    bus.resp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'd8, 32'd0, rd, flt, lat);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("stall_rdata", bus.resp_rdata, 32'h11223344);
      chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, bus.req_ready}, 32'd1);

    // flush during the second byte of a misaligned store
    wr_a.delete(); wr_d.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'd21; bus.req_wdata = 32'h01020304;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= bus.resp_valid;
      @(posedge clk); #1;
    end
    chk("flush_sw_noresp", {31'd0, seen}, 32'd0);
    chk("flush_sw_nwr", wr_a.size(), 32'd4);
    chk("flush_sw_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, F3_W, 32'd21, 32'd0, rd, flt, lat);
    chk("flush_sw_readback", rd, 32'h01020304);

    // flush during a misaligned load aborts immediately
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'd13;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_lw_idle", {31'd0, bus.req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= bus.resp_valid;
      @(posedge clk); #1;
    end
    chk("flush_lw_noresp", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
